// File: rtl/usbfs_in_sched.sv
// USB full-speed IN-transaction scheduler: answers IN tokens with STALL/NAK or a
// DATA0/DATA1 packet from a per-endpoint buffer, then waits for the host handshake.
module usbfs_in_sched #(
  parameter int unsigned N_ENDP      = 2,
  parameter int unsigned MAX_PKT     = 8,
  parameter int unsigned ACK_TIMEOUT = 18
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_tokenValid,
  output logic                                  o_tokenReady,
  input  logic [3:0]                            i_tokenEndp,
  input  logic [N_ENDP-1:0]                     i_etValid,
  input  logic [N_ENDP-1:0]                     i_etStall,
  input  logic [N_ENDP*8*MAX_PKT-1:0]           i_etData,
  input  logic [N_ENDP*($clog2(MAX_PKT)+1)-1:0] i_etData_nBytes,
  output logic [N_ENDP-1:0]                     o_etReady,
  output logic                                  o_txValid,
  input  logic                                  i_txReady,
  output logic [7:0]                            o_txData,
  output logic                                  o_txLast,
  input  logic                                  i_hsValid,
  input  logic                                  i_hsAck,
  input  logic [N_ENDP-1:0]                     i_clrToggle,
  output logic                                  o_busy
);

  localparam int unsigned PKT_W = 8 * MAX_PKT;
  localparam int unsigned NB_W  = $clog2(MAX_PKT) + 1;
  localparam int unsigned EP_W  = (N_ENDP > 1) ? $clog2(N_ENDP) : 1;
  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [7:0] PID_STALL = 8'h1E;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_WAIT_HS} state_t;

  state_t             r_state;
  logic [EP_W-1:0]    r_endp;
  logic [NB_W-1:0]    r_nbytes;
  logic [NB_W-1:0]    r_idx;
  logic [PKT_W-1:0]   r_pkt;
  logic               r_is_data;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_ENDP-1:0]  r_toggle;
  logic [N_ENDP-1:0]  r_et_ready;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic               r_tx_last;

  logic               w_tok_accept;
  logic               w_endp_ok;
  logic [EP_W-1:0]    w_ep;
  logic [PKT_W-1:0]   w_pkt;
  logic [NB_W-1:0]    w_nbytes;
  logic               w_is_data;
  logic [7:0]         w_pid;
  logic               w_hs_ack;
  logic [N_ENDP-1:0]  w_ack_mask;
  logic [NB_W-1:0]    w_idx_nxt;
  logic [NB_W-1:0]    w_nb_m1;
  logic [7:0]         w_byte_nxt;
  logic               w_nxt_last;

  // Token decode: endpoint selection and PID choice, all from the acceptance cycle
  assign w_tok_accept = i_tokenValid && (r_state == S_IDLE);
  assign w_endp_ok    = (32'(i_tokenEndp) < N_ENDP);
  assign w_ep         = i_tokenEndp[EP_W-1:0];
  assign w_pkt        = i_etData[32'(w_ep)*PKT_W +: PKT_W];
  assign w_nbytes     = i_etData_nBytes[32'(w_ep)*NB_W +: NB_W];
  assign w_is_data    = !i_etStall[w_ep] && i_etValid[w_ep];
  assign w_pid        = i_etStall[w_ep]  ? PID_STALL :
                        !i_etValid[w_ep] ? PID_NAK   :
                        r_toggle[w_ep]   ? PID_DATA1 : PID_DATA0;

  assign w_hs_ack   = (r_state == S_WAIT_HS) && i_hsValid && i_hsAck;
  assign w_ack_mask = w_hs_ack ? (N_ENDP'(1) << r_endp) : '0;

  assign w_idx_nxt  = r_idx + NB_W'(1);
  assign w_nb_m1    = r_nbytes - NB_W'(1);
  assign w_byte_nxt = r_pkt[32'(w_idx_nxt)*8 +: 8];
  assign w_nxt_last = (w_idx_nxt == w_nb_m1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_endp     <= '0;
      r_nbytes   <= '0;
      r_idx      <= '0;
      r_pkt      <= '0;
      r_is_data  <= 1'b0;
      r_cnt      <= '0;
      r_toggle   <= '0;
      r_et_ready <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_last  <= 1'b0;
    end else begin
      r_et_ready <= w_ack_mask;
      // A clear request wins over a same-cycle ACK flip
      r_toggle   <= (r_toggle ^ w_ack_mask) & ~i_clrToggle;
      case (r_state)
        S_IDLE: begin
          if (w_tok_accept && w_endp_ok) begin
            r_endp     <= w_ep;
            r_nbytes   <= w_nbytes;
            r_pkt      <= w_pkt;
            r_is_data  <= w_is_data;
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_pid;
            r_tx_last  <= !w_is_data;
            r_state    <= S_PID;
          end
        end
        S_PID: begin
          if (i_txReady) begin
            if (!r_is_data) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_state    <= S_IDLE;
            end else if (r_nbytes == '0) begin
              // Zero-length packet: PID alone, then await the handshake
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_cnt      <= '0;
              r_state    <= S_WAIT_HS;
            end else begin
              r_idx      <= '0;
              r_tx_data  <= r_pkt[7:0];
              r_tx_last  <= (r_nbytes == NB_W'(1));
              r_state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (i_txReady) begin
            if (r_tx_last) begin
              r_tx_valid <= 1'b0;
              r_tx_last  <= 1'b0;
              r_cnt      <= '0;
              r_state    <= S_WAIT_HS;
            end else begin
              r_idx      <= w_idx_nxt;
              r_tx_data  <= w_byte_nxt;
              r_tx_last  <= w_nxt_last;
            end
          end
        end
        S_WAIT_HS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (i_hsValid || (r_cnt == CNT_W'(ACK_TIMEOUT - 1))) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tokenReady = (r_state == S_IDLE);
  assign o_busy       = (r_state != S_IDLE);
  assign o_etReady    = r_et_ready;
  assign o_txValid    = r_tx_valid;
  assign o_txData     = r_tx_data;
  assign o_txLast     = r_tx_last;

endmodule

// File: tb/tb_usbfs_in_sched.sv
// Directed bench for usbfs_in_sched: data/ACK, NAK/STALL, backpressure, timeout,
// toggle-clear race, invalid endpoint and mid-packet reset.
module tb_usbfs_in_sched;

  localparam int unsigned N_ENDP      = 2;
  localparam int unsigned MAX_PKT     = 8;
  localparam int unsigned ACK_TIMEOUT = 18;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         token_valid = 1'b0;
  logic         token_ready;
  logic [3:0]   token_endp = 4'd0;
  logic [1:0]   et_valid = 2'b00;
  logic [1:0]   et_stall = 2'b00;
  logic [127:0] et_data = '0;
  logic [7:0]   et_nbytes = '0;
  logic [1:0]   et_ready;
  logic         tx_valid;
  logic         tx_ready = 1'b1;
  logic [7:0]   tx_data;
  logic         tx_last;
  logic         hs_valid = 1'b0;
  logic         hs_ack = 1'b0;
  logic [1:0]   clr_toggle = 2'b00;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [7:0] cap_data [16];
  logic       cap_last [16];
  int         cap_n;

  usbfs_in_sched #(.N_ENDP(N_ENDP), .MAX_PKT(MAX_PKT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tokenValid(token_valid), .o_tokenReady(token_ready), .i_tokenEndp(token_endp),
    .i_etValid(et_valid), .i_etStall(et_stall), .i_etData(et_data),
    .i_etData_nBytes(et_nbytes), .o_etReady(et_ready),
    .o_txValid(tx_valid), .i_txReady(tx_ready), .o_txData(tx_data), .o_txLast(tx_last),
    .i_hsValid(hs_valid), .i_hsAck(hs_ack), .i_clrToggle(clr_toggle), .o_busy(busy)
  );

  always #5 clk = ~clk;

  // Counts cycles in which o_etReady was non-zero (sampled before the edge updates it)
  always @(posedge clk) if (et_ready != 2'b00) pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic load_ep(input int ep, input int n, input logic [63:0] bytes);
    et_data[ep*64 +: 64] = bytes;
    et_nbytes[ep*4 +: 4] = 4'(n);
  endtask

  task automatic send_token(input logic [3:0] ep);
    token_valid = 1'b1;
    token_endp  = ep;
    @(negedge clk);
    token_valid = 1'b0;
  endtask

  task automatic send_hs(input logic ack, input logic [1:0] clr);
    hs_valid   = 1'b1;
    hs_ack     = ack;
    clr_toggle = clr;
    @(negedge clk);
    hs_valid   = 1'b0;
    hs_ack     = 1'b0;
    clr_toggle = 2'b00;
  endtask

  // Records accepted bytes until the last one is taken (bounded)
  task automatic collect();
    cap_n = 0;
    for (int c = 0; c < 40; c++) begin
      if (tx_valid && tx_ready) begin
        if (cap_n < 16) begin
          cap_data[cap_n] = tx_data;
          cap_last[cap_n] = tx_last;
        end
        cap_n++;
        if (tx_last) begin
          @(negedge clk);
          return;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_tx_last: got %b expected 0", tx_last); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
    checks++; if (et_ready !== 2'b00) begin errors++; $display("FAIL rst_et_ready: got %b expected 00", et_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (token_ready !== 1'b1) begin errors++; $display("FAIL rst_token_ready: got %b expected 1", token_ready); end
  endtask

  task automatic test_data_ack();
    logic [7:0] exp [4] = '{8'hC3, 8'h11, 8'h22, 8'h33};
    logic [3:0] lm;
    int p0;
    load_ep(1, 3, 64'h0000_0000_0033_2211);
    et_valid = 2'b10;
    send_token(4'd1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL data_busy: got %b expected 1", busy); end
    collect();
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL data_len: got %0d expected 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap_data[i] !== exp[i]) begin errors++; $display("FAIL data_byte%0d: got %h expected %h", i, cap_data[i], exp[i]); end
    end
    lm = {cap_last[3], cap_last[2], cap_last[1], cap_last[0]};
    checks++; if (lm !== 4'b1000) begin errors++; $display("FAIL data_last: got %b expected 1000", lm); end
    p0 = pulses;
    send_hs(1'b1, 2'b00);
    checks++; if (et_ready !== 2'b10) begin errors++; $display("FAIL ack_et_ready: got %b expected 10", et_ready); end
    @(negedge clk);
    checks++; if (et_ready !== 2'b00) begin errors++; $display("FAIL ack_et_ready_drop: got %b expected 00", et_ready); end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL ack_pulse_cnt: got %0d expected 1", pulses - p0); end
    send_token(4'd1);
    collect();
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL data1_len: got %0d expected 4", cap_n); end
    checks++; if (cap_data[0] !== 8'h4B) begin errors++; $display("FAIL data1_pid: got %h expected 4b", cap_data[0]); end
    checks++; if (cap_data[3] !== 8'h33) begin errors++; $display("FAIL data1_tail: got %h expected 33", cap_data[3]); end
    send_hs(1'b1, 2'b00);
    @(negedge clk);
  endtask

  task automatic test_nak_stall();
    int p0;
    et_valid[0] = 1'b0;
    p0 = pulses;
    send_token(4'd0);
    collect();
    checks++; if (cap_n !== 1) begin errors++; $display("FAIL nak_len: got %0d expected 1", cap_n); end
    checks++; if (cap_data[0] !== 8'h5A) begin errors++; $display("FAIL nak_pid: got %h expected 5a", cap_data[0]); end
    checks++; if (cap_last[0] !== 1'b1) begin errors++; $display("FAIL nak_last: got %b expected 1", cap_last[0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nak_idle: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (pulses !== p0) begin errors++; $display("FAIL nak_no_pulse: got %0d expected %0d", pulses, p0); end
    load_ep(0, 2, 64'h0000_0000_0000_7766);
    et_valid[0] = 1'b1;
    et_stall[0] = 1'b1;
    send_token(4'd0);
    collect();
    checks++; if (cap_n !== 1) begin errors++; $display("FAIL stall_len: got %0d expected 1", cap_n); end
    checks++; if (cap_data[0] !== 8'h1E) begin errors++; $display("FAIL stall_pid: got %h expected 1e", cap_data[0]); end
    checks++; if (cap_last[0] !== 1'b1) begin errors++; $display("FAIL stall_last: got %b expected 1", cap_last[0]); end
    et_stall[0] = 1'b0;
  endtask

  task automatic test_backpressure_timeout();
    logic [7:0] exp [3] = '{8'hBB, 8'hCC, 8'hDD};
    int p0;
    int k;
    load_ep(1, 4, 64'h0000_0000_DDCC_BBAA);
    send_token(4'd1);
    @(negedge clk);
    @(negedge clk);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({tx_valid, tx_last, tx_data} !== {1'b1, 1'b0, 8'hBB}) begin
        errors++; $display("FAIL hold_%0d: got v=%b l=%b d=%h expected v=1 l=0 d=bb", i, tx_valid, tx_last, tx_data);
      end
    end
    tx_ready = 1'b1;
    collect();
    checks++; if (cap_n !== 3) begin errors++; $display("FAIL bp_len: got %0d expected 3", cap_n); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (cap_data[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, cap_data[i], exp[i]); end
    end
    checks++; if ({cap_last[2], cap_last[1], cap_last[0]} !== 3'b100) begin errors++; $display("FAIL bp_last: got %b%b%b expected 100", cap_last[2], cap_last[1], cap_last[0]); end
    p0 = pulses;
    k = 0;
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 18) begin errors++; $display("FAIL timeout_cycles: got %0d expected 18", k); end
    checks++; if (pulses !== p0) begin errors++; $display("FAIL timeout_no_pulse: got %0d expected %0d", pulses, p0); end
    send_token(4'd1);
    collect();
    checks++; if (cap_n !== 5) begin errors++; $display("FAIL retry_len: got %0d expected 5", cap_n); end
    checks++; if (cap_data[0] !== 8'hC3) begin errors++; $display("FAIL retry_pid: got %h expected c3", cap_data[0]); end
    checks++; if (cap_data[4] !== 8'hDD) begin errors++; $display("FAIL retry_tail: got %h expected dd", cap_data[4]); end
    p0 = pulses;
    send_hs(1'b0, 2'b00);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nakhs_idle: got %b expected 0", busy); end
    checks++; if (et_ready !== 2'b00) begin errors++; $display("FAIL nakhs_et_ready: got %b expected 00", et_ready); end
    @(negedge clk);
    checks++; if (pulses !== p0) begin errors++; $display("FAIL nakhs_no_pulse: got %0d expected %0d", pulses, p0); end
    send_token(4'd1);
    collect();
    checks++; if (cap_data[0] !== 8'hC3) begin errors++; $display("FAIL nakhs_retry_pid: got %h expected c3", cap_data[0]); end
  endtask

  task automatic test_clr_race();
    send_hs(1'b1, 2'b10);
    checks++; if (et_ready !== 2'b10) begin errors++; $display("FAIL race_et_ready: got %b expected 10", et_ready); end
    send_token(4'd1);
    collect();
    checks++; if (cap_data[0] !== 8'hC3) begin errors++; $display("FAIL race_pid: got %h expected c3", cap_data[0]); end
    send_hs(1'b1, 2'b00);
    @(negedge clk);
    token_valid = 1'b1;
    token_endp  = 4'd5;
    @(negedge clk);
    token_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badep_busy: got %b expected 0", busy); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL badep_tx: got %b expected 0", tx_valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badep_busy2: got %b expected 0", busy); end
    checks++; if (token_ready !== 1'b1) begin errors++; $display("FAIL badep_ready: got %b expected 1", token_ready); end
  endtask

  task automatic test_reset_mid();
    int p0;
    load_ep(1, 3, 64'h0000_0000_0033_2211);
    send_token(4'd1);
    checks++; if (tx_data !== 8'h4B) begin errors++; $display("FAIL rmid_pid: got %h expected 4b", tx_data); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (tx_data !== 8'h22) begin errors++; $display("FAIL rmid_byte: got %h expected 22", tx_data); end
    p0 = pulses;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rmid_async_valid: got %b expected 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_async_busy: got %b expected 0", busy); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (token_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b expected 1", token_ready); end
    checks++; if (pulses !== p0) begin errors++; $display("FAIL rmid_no_pulse: got %0d expected %0d", pulses, p0); end
    send_token(4'd1);
    collect();
    checks++; if (cap_n !== 4) begin errors++; $display("FAIL rmid_len: got %0d expected 4", cap_n); end
    checks++; if (cap_data[0] !== 8'hC3) begin errors++; $display("FAIL rmid_pid_after: got %h expected c3", cap_data[0]); end
    send_hs(1'b1, 2'b00);
    checks++; if (et_ready !== 2'b10) begin errors++; $display("FAIL rmid_ack: got %b expected 10", et_ready); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_data_ack();
    test_nak_stall();
    test_backpressure_timeout();
    test_clr_race();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
